ysyx_23060236_axi_sram: RTL and testbench

//  AXI4 slave (responder) memory model; sits at the far end of the core's io_master bus (after the MMU).

---
 rtl/ysyx_23060236_axi_sram.sv | 224 ++++++++++++++++++++++
 tb/tb_ysyx_23060236_axi_sram.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060236_axi_sram.sv
// AXI4 slave memory model: independent read/write engines over one word array,
// one outstanding transaction per direction, INCR/FIXED bursts, byte strobes.
module ysyx_23060236_axi_sram #(
  parameter int          ADDR_W = 10,
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter int          RD_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  // write address
  output logic        io_slave_awready,
  input  logic        io_slave_awvalid,
  input  logic [31:0] io_slave_awaddr,
  input  logic [3:0]  io_slave_awid,
  input  logic [7:0]  io_slave_awlen,
  input  logic [2:0]  io_slave_awsize,
  input  logic [1:0]  io_slave_awburst,
  // write data
  output logic        io_slave_wready,
  input  logic        io_slave_wvalid,
  input  logic [31:0] io_slave_wdata,
  input  logic [3:0]  io_slave_wstrb,
  input  logic        io_slave_wlast,
  // write response
  input  logic        io_slave_bready,
  output logic        io_slave_bvalid,
  output logic [1:0]  io_slave_bresp,
  output logic [3:0]  io_slave_bid,
  // read address
  output logic        io_slave_arready,
  input  logic        io_slave_arvalid,
  input  logic [31:0] io_slave_araddr,
  input  logic [3:0]  io_slave_arid,
  input  logic [7:0]  io_slave_arlen,
  input  logic [2:0]  io_slave_arsize,
  input  logic [1:0]  io_slave_arburst,
  // read data
  input  logic        io_slave_rready,
  output logic        io_slave_rvalid,
  output logic [1:0]  io_slave_rresp,
  output logic [31:0] io_slave_rdata,
  output logic        io_slave_rlast,
  output logic [3:0]  io_slave_rid
);

  localparam int         DEPTH  = 1 << ADDR_W;
  localparam logic [7:0] LAT_M1 = 8'(RD_LAT - 1);
  localparam logic [1:0] SLVERR = 2'b10;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [31:0] r_mem [0:DEPTH-1];

  // in range iff BASE <= a < BASE + 4*DEPTH (offset fits in ADDR_W+2 bits)
  function automatic logic f_in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a >= BASE) && (off[31:ADDR_W+2] == '0);
  endfunction

  function automatic logic [ADDR_W-1:0] f_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off[ADDR_W+1:2];
  endfunction

  // FIXED holds the address; INCR, WRAP and reserved all step by the beat size
  function automatic logic [31:0] f_next(input logic [31:0] a, input logic [2:0] sz,
                                         input logic [1:0] burst);
    logic [1:0] s;
    s = (sz > 3'd2) ? 2'd2 : sz[1:0];
    return (burst == 2'b00) ? a : a + (32'd1 << s);
  endfunction

  // ---------------- read engine ----------------
  logic [1:0]  r_rstate;
  logic [3:0]  r_rid;
  logic [31:0] r_raddr;
  logic [7:0]  r_rlen, r_rbeat, r_rcnt;
  logic [2:0]  r_rsize;
  logic [1:0]  r_rburst, r_rresp;
  logic        r_rvalid, r_rlast;
  logic [31:0] r_rdata;
  logic        w_rin;

  assign w_rin = f_in_range(r_raddr);

  // read FSM: accept AR, count latency, present one beat until accepted
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rstate <= R_IDLE;
      r_rid    <= '0;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rbeat  <= '0;
      r_rcnt   <= '0;
      r_rsize  <= '0;
      r_rburst <= '0;
      r_rresp  <= '0;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
      r_rdata  <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: if (io_slave_arvalid) begin
          r_rid    <= io_slave_arid;
          r_raddr  <= io_slave_araddr;
          r_rlen   <= io_slave_arlen;
          r_rsize  <= io_slave_arsize;
          r_rburst <= io_slave_arburst;
          r_rbeat  <= '0;
          r_rcnt   <= LAT_M1;
          r_rstate <= R_WAIT;
        end
        R_WAIT: if (r_rcnt == '0) begin
          r_rvalid <= 1'b1;
          r_rlast  <= (r_rbeat == r_rlen);
          r_rdata  <= w_rin ? r_mem[f_idx(r_raddr)] : 32'h0;
          r_rresp  <= w_rin ? 2'b00 : SLVERR;
          r_rstate <= R_DATA;
        end else begin
          r_rcnt <= r_rcnt - 8'd1;
        end
        R_DATA: if (io_slave_rready) begin
          r_rvalid <= 1'b0;
          r_rlast  <= 1'b0;
          if (r_rlast) begin
            r_rstate <= R_IDLE;
          end else begin
            r_rbeat  <= r_rbeat + 8'd1;
            r_raddr  <= f_next(r_raddr, r_rsize, r_rburst);
            r_rcnt   <= LAT_M1;
            r_rstate <= R_WAIT;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign io_slave_arready = (r_rstate == R_IDLE);
  assign io_slave_rvalid  = r_rvalid;
  assign io_slave_rlast   = r_rlast;
  assign io_slave_rdata   = r_rdata;
  assign io_slave_rresp   = r_rresp;
  assign io_slave_rid     = r_rid;

  // ---------------- write engine ----------------
  logic [1:0]  r_wstate;
  logic [3:0]  r_wid;
  logic [31:0] r_waddr;
  logic [7:0]  r_wlen, r_wbeat;
  logic [2:0]  r_wsize;
  logic [1:0]  r_wburst, r_bresp;
  logic        r_werr;
  logic        w_win, w_wlast_exp, w_wend, w_wbeat_err, w_whs;

  assign w_win       = f_in_range(r_waddr);
  assign w_wlast_exp = (r_wbeat == r_wlen);
  assign w_wend      = io_slave_wlast | w_wlast_exp;
  assign w_wbeat_err = !w_win | (io_slave_wlast != w_wlast_exp);
  assign w_whs       = (r_wstate == W_DATA) && io_slave_wvalid;

  // write FSM: accept AW, take beats until wlast or len reached, then respond
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wstate <= W_IDLE;
      r_wid    <= '0;
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wbeat  <= '0;
      r_wsize  <= '0;
      r_wburst <= '0;
      r_werr   <= 1'b0;
      r_bresp  <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: if (io_slave_awvalid) begin
          r_wid    <= io_slave_awid;
          r_waddr  <= io_slave_awaddr;
          r_wlen   <= io_slave_awlen;
          r_wsize  <= io_slave_awsize;
          r_wburst <= io_slave_awburst;
          r_wbeat  <= '0;
          r_werr   <= 1'b0;
          r_wstate <= W_DATA;
        end
        W_DATA: if (io_slave_wvalid) begin
          if (w_wend) begin
            r_bresp  <= (r_werr | w_wbeat_err) ? SLVERR : 2'b00;
            r_wstate <= W_RESP;
          end else begin
            r_werr  <= r_werr | w_wbeat_err;
            r_wbeat <= r_wbeat + 8'd1;
            r_waddr <= f_next(r_waddr, r_wsize, r_wburst);
          end
        end
        W_RESP: if (io_slave_bready) r_wstate <= W_IDLE;
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // array update: strobed bytes of in-range beats; contents survive reset
  always_ff @(posedge clock) begin
    if (w_whs && w_win) begin
      for (int i = 0; i < 4; i++) begin
        if (io_slave_wstrb[i]) r_mem[f_idx(r_waddr)][8*i +: 8] <= io_slave_wdata[8*i +: 8];
      end
    end
  end

  assign io_slave_awready = (r_wstate == W_IDLE);
  assign io_slave_wready  = (r_wstate == W_DATA);
  assign io_slave_bvalid  = (r_wstate == W_RESP);
  assign io_slave_bresp   = r_bresp;
  assign io_slave_bid     = r_wid;

endmodule

// File: tb/tb_ysyx_23060236_axi_sram.sv
// Directed bench for the AXI SRAM model: drives on negedge, checks on negedge.
module tb_ysyx_23060236_axi_sram;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        awready, awvalid, wready, wvalid, wlast, bready, bvalid;
  logic        arready, arvalid, rready, rvalid, rlast;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  awid, arid, wstrb, bid, rid;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;

  always #5 clock = ~clock;

  ysyx_23060236_axi_sram dut (
    .clock(clock), .reset(reset),
    .io_slave_awready(awready), .io_slave_awvalid(awvalid), .io_slave_awaddr(awaddr),
    .io_slave_awid(awid), .io_slave_awlen(awlen), .io_slave_awsize(awsize),
    .io_slave_awburst(awburst),
    .io_slave_wready(wready), .io_slave_wvalid(wvalid), .io_slave_wdata(wdata),
    .io_slave_wstrb(wstrb), .io_slave_wlast(wlast),
    .io_slave_bready(bready), .io_slave_bvalid(bvalid), .io_slave_bresp(bresp),
    .io_slave_bid(bid),
    .io_slave_arready(arready), .io_slave_arvalid(arvalid), .io_slave_araddr(araddr),
    .io_slave_arid(arid), .io_slave_arlen(arlen), .io_slave_arsize(arsize),
    .io_slave_arburst(arburst),
    .io_slave_rready(rready), .io_slave_rvalid(rvalid), .io_slave_rresp(rresp),
    .io_slave_rdata(rdata), .io_slave_rlast(rlast), .io_slave_rid(rid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id);
    int n = 0;
    awaddr = a; awlen = len; awid = id; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    while (!awready && n < 50) begin @(negedge clock); n++; end
    if (n >= 50) chk("aw_timeout", {31'b0, awready}, 32'd1);
    @(negedge clock);
    awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic l);
    int n = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    while (!wready && n < 50) begin @(negedge clock); n++; end
    if (n >= 50) chk("w_timeout", {31'b0, wready}, 32'd1);
    @(negedge clock);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_check(input string tag, input logic [3:0] id, input logic [1:0] resp);
    int n = 0;
    while (!bvalid && n < 50) begin @(negedge clock); n++; end
    chk({tag, "_bvalid"}, {31'b0, bvalid}, 32'd1);
    chk({tag, "_bid"}, {28'b0, bid}, {28'b0, id});
    chk({tag, "_bresp"}, {30'b0, bresp}, {30'b0, resp});
    bready = 1'b1;
    @(negedge clock);
    bready = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id);
    int n = 0;
    araddr = a; arlen = len; arid = id; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    while (!arready && n < 50) begin @(negedge clock); n++; end
    if (n >= 50) chk("ar_timeout", {31'b0, arready}, 32'd1);
    @(negedge clock);
    arvalid = 1'b0;
  endtask

  task automatic r_check(input string tag, input logic [31:0] d, input logic l,
                         input logic [1:0] resp, input logic [3:0] id, output int wait_n);
    wait_n = 0;
    while (!rvalid && wait_n < 50) begin @(negedge clock); wait_n++; end
    chk({tag, "_rvalid"}, {31'b0, rvalid}, 32'd1);
    chk({tag, "_rdata"}, rdata, d);
    chk({tag, "_rlast"}, {31'b0, rlast}, {31'b0, l});
    chk({tag, "_rresp"}, {30'b0, rresp}, {30'b0, resp});
    chk({tag, "_rid"}, {28'b0, rid}, {28'b0, id});
    rready = 1'b1;
    @(negedge clock);
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;

    // reset state
    repeat (2) @(negedge clock);
    chk("rst_awready", {31'b0, awready}, 32'd1);
    chk("rst_arready", {31'b0, arready}, 32'd1);
    chk("rst_wready",  {31'b0, wready},  32'd0);
    chk("rst_bvalid",  {31'b0, bvalid},  32'd0);
    chk("rst_rvalid",  {31'b0, rvalid},  32'd0);
    chk("rst_rlast",   {31'b0, rlast},   32'd0);
    chk("rst_rresp",   {30'b0, rresp},   32'd0);
    chk("rst_bresp",   {30'b0, bresp},   32'd0);
    chk("rst_rdata",   rdata,            32'd0);
    chk("rst_rid",     {28'b0, rid},     32'd0);
    chk("rst_bid",     {28'b0, bid},     32'd0);
    reset = 1'b1;
    @(negedge clock);

    // 1: single write then read, first rvalid one negedge after AR handshake
    aw_send(32'h8000_0010, 8'd0, 4'd3);
    chk("t1_wready", {31'b0, wready}, 32'd1);
    w_send(32'hDEAD_BEEF, 4'hF, 1'b1);
    b_check("t1", 4'd3, 2'b00);
    ar_send(32'h8000_0010, 8'd0, 4'd3);
    r_check("t1", 32'hDEAD_BEEF, 1'b1, 2'b00, 4'd3, lat);
    chk("t1_lat", lat, 32'd1);

    // 2: preload words 0..3 with 1..4, INCR read burst of 4
    aw_send(BASE, 8'd3, 4'd1);
    for (int i = 0; i < 4; i++) w_send(32'(i + 1), 4'hF, i == 3);
    b_check("t2", 4'd1, 2'b00);
    ar_send(BASE, 8'd3, 4'd2);
    for (int i = 0; i < 4; i++) begin
      r_check($sformatf("t2_b%0d", i), 32'(i + 1), i == 3, 2'b00, 4'd2, lat);
      chk($sformatf("t2_lat%0d", i), lat, 32'd1);
    end

    // 3: byte strobes
    aw_send(32'h8000_0014, 8'd0, 4'd4);
    w_send(32'h1122_3344, 4'hF, 1'b1);
    b_check("t3a", 4'd4, 2'b00);
    aw_send(32'h8000_0014, 8'd0, 4'd4);
    w_send(32'hAABB_CCDD, 4'b0101, 1'b1);
    b_check("t3b", 4'd4, 2'b00);
    ar_send(32'h8000_0014, 8'd0, 4'd4);
    r_check("t3", 32'h11BB_33DD, 1'b1, 2'b00, 4'd4, lat);

    // 4: out of range below and above; top word stays in range
    ar_send(32'h7FFF_FFFC, 8'd0, 4'd5);
    r_check("t4_lo", 32'h0, 1'b1, 2'b10, 4'd5, lat);
    aw_send(32'h8000_1000, 8'd0, 4'd6);
    w_send(32'hFFFF_FFFF, 4'hF, 1'b1);
    b_check("t4_hi", 4'd6, 2'b10);
    ar_send(BASE, 8'd0, 4'd7);
    r_check("t4_w0", 32'd1, 1'b1, 2'b00, 4'd7, lat);
    aw_send(32'h8000_0FFC, 8'd0, 4'd6);
    w_send(32'h0F0F_0F0F, 4'hF, 1'b1);
    b_check("t4_top", 4'd6, 2'b00);
    ar_send(32'h8000_0FFC, 8'd0, 4'd7);
    r_check("t4_top", 32'h0F0F_0F0F, 1'b1, 2'b00, 4'd7, lat);

    // 5: rready backpressure holds the beat stable
    ar_send(BASE, 8'd3, 4'd8);
    r_check("t5_b0", 32'd1, 1'b0, 2'b00, 4'd8, lat);
    @(negedge clock);
    for (int k = 0; k < 10; k++) begin
      chk("t5_hold_rvalid", {31'b0, rvalid}, 32'd1);
      chk("t5_hold_rdata", rdata, 32'd2);
      chk("t5_hold_rlast", {31'b0, rlast}, 32'd0);
      @(negedge clock);
    end
    r_check("t5_b1", 32'd2, 1'b0, 2'b00, 4'd8, lat);
    chk("t5_b1_lat", lat, 32'd0);
    r_check("t5_b2", 32'd3, 1'b0, 2'b00, 4'd8, lat);
    r_check("t5_b3", 32'd4, 1'b1, 2'b00, 4'd8, lat);
    // early wlast: len=1 but wlast on beat 0
    aw_send(32'h8000_0018, 8'd1, 4'd9);
    w_send(32'h0000_0066, 4'hF, 1'b1);
    b_check("t5_early", 4'd9, 2'b10);
    chk("t5_wready_after", {31'b0, wready}, 32'd0);
    ar_send(32'h8000_0018, 8'd0, 4'd9);
    r_check("t5_w6", 32'h0000_0066, 1'b1, 2'b00, 4'd9, lat);

    // 6: read and write of the same word in the same cycle returns old data
    aw_send(32'h8000_001C, 8'd0, 4'd10);
    w_send(32'h1234_5678, 4'hF, 1'b1);
    b_check("t6a", 4'd10, 2'b00);
    aw_send(32'h8000_001C, 8'd0, 4'd11);
    araddr = 32'h8000_001C; arlen = 8'd0; arid = 4'd12; arsize = 3'd2; arburst = 2'b01;
    arvalid = 1'b1;
    @(negedge clock);
    arvalid = 1'b0;
    wdata = 32'hCAFE_F00D; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    @(negedge clock);
    wvalid = 1'b0; wlast = 1'b0;
    r_check("t6_old", 32'h1234_5678, 1'b1, 2'b00, 4'd12, lat);
    chk("t6_old_lat", lat, 32'd0);
    b_check("t6b", 4'd11, 2'b00);
    ar_send(32'h8000_001C, 8'd0, 4'd12);
    r_check("t6_new", 32'hCAFE_F00D, 1'b1, 2'b00, 4'd12, lat);

    // reset mid-burst: responses dropped, committed beat kept
    aw_send(32'h8000_0020, 8'd3, 4'd13);
    w_send(32'h5555_5555, 4'hF, 1'b0);
    ar_send(BASE, 8'd3, 4'd14);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("t6_rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("t6_rst_bvalid", {31'b0, bvalid}, 32'd0);
    chk("t6_rst_wready", {31'b0, wready}, 32'd0);
    chk("t6_rst_rlast",  {31'b0, rlast},  32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("t6_post_awready", {31'b0, awready}, 32'd1);
    chk("t6_post_arready", {31'b0, arready}, 32'd1);
    chk("t6_post_rvalid",  {31'b0, rvalid},  32'd0);
    chk("t6_post_bvalid",  {31'b0, bvalid},  32'd0);
    ar_send(32'h8000_0020, 8'd0, 4'd15);
    r_check("t6_partial", 32'h5555_5555, 1'b1, 2'b00, 4'd15, lat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
